// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: controller states, default loop
// sizing and the control-line indices the A/Q/M datapath registers decode.
package div_pkg;

    localparam int ITER_DEF  = 16;
    localparam int CNT_W_DEF = 4;

    // Bit positions of c0..c9 on the datapath control bus (c7 is reserved).
    localparam int C_LD_A    = 0;
    localparam int C_LD_Q    = 1;
    localparam int C_LD_M    = 2;
    localparam int C_A_ADD   = 3;
    localparam int C_SUB_OP  = 4;
    localparam int C_WR_Q0   = 5;
    localparam int C_SHIFT   = 6;
    localparam int C_OUT_A   = 8;
    localparam int C_OUT_Q   = 9;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_A,
        S_LD_Q,
        S_LD_M,
        S_SHIFT,
        S_SUB,
        S_TEST,
        S_RESTORE,
        S_OUT_R,
        S_OUT_Q,
        S_DONE
    } div_state_e;

endpackage

// File: rtl/div_iter_cnt.sv
// Iteration counter for the divider loop: synchronous clear/increment, flags the
// final iteration.
module div_iter_cnt #(
    parameter int ITER  = 16,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign last = (cnt_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/div_ctrl_unit.sv
// Sequencer for the 16-bit unsigned restoring divider datapath.
// Optional divide-by-zero bypass and err flag: define DIV0_CHECK_EN.
module div_ctrl_unit
    import div_pkg::*;
#(
    parameter int ITER  = ITER_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_b,
    input  logic start,
    input  logic a_sign,
    input  logic m_zero,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic c3,
    output logic c4,
    output logic c5,
    output logic c6,
    output logic c8,
    output logic c9,
    output logic qbit,
    output logic busy,
    output logic done,
    output logic err
);

`ifdef DIV0_CHECK_EN
    localparam bit DIV0_EN = 1'b1;
`else
    localparam bit DIV0_EN = 1'b0;
`endif

    div_state_e state_q, state_d;
    logic       cnt_clr, cnt_inc, cnt_last;
    logic       err_q, err_d;

    div_iter_cnt #(
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .last  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        err_d   = err_q;
        {c0, c1, c2, c3, c4, c5, c6, c8, c9, qbit, done} = '0;
        busy    = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_LD_A;
                    err_d   = 1'b0;
                end
            end
            S_LD_A: begin
                c0      = 1'b1;
                state_d = S_LD_Q;
            end
            S_LD_Q: begin
                c1      = 1'b1;
                state_d = S_LD_M;
            end
            S_LD_M: begin
                c2 = 1'b1;
                // Zero divisor skips the loop so A/Q come out untouched.
                if (DIV0_EN && m_zero) begin
                    state_d = S_OUT_R;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                c6      = 1'b1;
                state_d = S_SUB;
            end
            S_SUB: begin
                c3      = 1'b1;
                c4      = 1'b1;
                state_d = S_TEST;
            end
            S_TEST, S_RESTORE: begin
                if (state_q == S_TEST) begin
                    c5   = 1'b1;
                    qbit = ~a_sign;
                end else begin
                    c3 = 1'b1;
                end
                if (state_q == S_TEST && a_sign) begin
                    state_d = S_RESTORE;
                end else if (cnt_last) begin
                    cnt_clr = 1'b1;
                    state_d = S_OUT_R;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_OUT_R: begin
                c8      = 1'b1;
                state_d = S_OUT_Q;
            end
            S_OUT_Q: begin
                c9      = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign err = DIV0_EN & err_q;

endmodule

// File: tb/tb_div_ctrl_unit.sv
// Self-checking bench for div_ctrl_unit with behavioural A/Q/M/adder datapath.
// Results are compared against plain integer division; build with or without DIV0_CHECK_EN.
module tb_div_ctrl_unit;

    logic clk = 1'b0, rst_b = 1'b0, start = 1'b0;
    logic a_sign, m_zero;
    logic c0, c1, c2, c3, c4, c5, c6, c8, c9, qbit, busy, done, err;

    div_ctrl_unit dut (
        .clk(clk), .rst_b(rst_b), .start(start), .a_sign(a_sign), .m_zero(m_zero),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c8(c8), .c9(c9),
        .qbit(qbit), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural datapath; host word on inbus is modelled by hi_word/dvd_in/dvs_in.
    logic [15:0] dp_a = '0, dp_q = '0, dp_m = '0;
    logic [15:0] hi_word = '0, dvd_in = '0, dvs_in = '0;

    always @(posedge clk) begin
        if (c0) dp_a <= hi_word;
        if (c1) dp_q <= dvd_in;
        if (c2) dp_m <= dvs_in;
        if (c3) dp_a <= c4 ? dp_a - dp_m : dp_a + dp_m;
        if (c5) dp_q[0] <= qbit;
        if (c6) {dp_a, dp_q} <= {dp_a, dp_q} << 1;
    end

    assign a_sign = dp_a[15];
    assign m_zero = c2 ? (dvs_in == 16'd0) : (dp_m == 16'd0);

    logic [12:0] outs;
    assign outs = {c0, c1, c2, c3, c4, c5, c6, c8, c9, qbit, busy, done, err};

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Per-run observations
    int n_c0, n_c5, n_c6, n_done, done_cyc, c2_cyc, c8_cyc, viol, n_err;
    logic [15:0] got_r, got_q;
    logic err_at_r, err_end;

    task automatic clr_obs();
        n_c0 = 0; n_c5 = 0; n_c6 = 0; n_done = 0; n_err = 0; viol = 0;
        done_cyc = -1; c2_cyc = -1; c8_cyc = -1;
        got_r = '0; got_q = '0; err_at_r = 1'b0;
    endtask

    task automatic sample(input int cyc);
        logic [7:0] ctl;
        ctl = {c0, c1, c2, c3, c5, c6, c8, c9};
        if ($countones(ctl) != (busy ? 1 : 0)) viol++;
        if (c4 && !c3) viol++;
        if (qbit && !c5) viol++;
        if (done && busy) viol++;
        if (c0) n_c0++;
        if (c5) n_c5++;
        if (c6) n_c6++;
        if (err) n_err++;
        if (c2) c2_cyc = cyc;
        if (c8 && c8_cyc < 0) begin
            c8_cyc = cyc; got_r = dp_a; err_at_r = err;
        end
        if (c9) got_q = dp_q;
        if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
    endtask

    // start is sampled at edge 0; cycle n is the period after edge n-1.
    task automatic run_div(input logic [15:0] dvd, input logic [15:0] dvs, input bit hold);
        clr_obs();
        dvd_in = dvd; dvs_in = dvs; hi_word = 16'd0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            sample(cyc);
            if (done) start = 1'b0;
            if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
        end
        start = 1'b0;
        err_end = err;
    endtask

    task automatic check_div(input logic [15:0] dvd, input logic [15:0] dvs, input bit hold);
        int q, r, rest;
        string t;
        q = int'(dvd) / int'(dvs);
        r = int'(dvd) % int'(dvs);
        rest = 16 - $countones(q[15:0]);
        t = $sformatf("%0d/%0d", dvd, dvs);
        run_div(dvd, dvs, hold);
        chk({t, " quotient"}, got_q, q);
        chk({t, " remainder"}, got_r, r);
        chk({t, " done_cycle"}, done_cyc, 54 + rest);
        chk({t, " done_pulses"}, n_done, 1);
        chk({t, " loads"}, n_c0, 1);
        chk({t, " shifts"}, n_c6, 16);
        chk({t, " qwrites"}, n_c5, 16);
        chk({t, " ctl_rules"}, viol, 0);
        chk({t, " err"}, err_end, 0);
    endtask

    initial begin
        // Reset behaviour, including a start pulse while held in reset
        clr_obs();
        repeat (2) @(negedge clk);
        chk("reset_outs", outs, 13'd0);
        start = 1'b1;
        @(negedge clk);
        chk("reset_outs_start", outs, 13'd0);
        start = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sample(0);
        end
        chk("post_reset_idle_loads", n_c0, 0);
        chk("post_reset_idle_outs", outs, 13'd0);

        check_div(16'd100, 16'd7, 1'b0);
        check_div(16'hFFFF, 16'd1, 1'b0);
        check_div(16'd5, 16'd10, 1'b0);

        // Divide by zero
`ifdef DIV0_CHECK_EN
        run_div(16'd1234, 16'd0, 1'b0);
        chk("div0 out_r_after_ld_m", c8_cyc, c2_cyc + 1);
        chk("div0 out_r_cycle", c8_cyc, 4);
        chk("div0 shifts", n_c6, 0);
        chk("div0 a_out", got_r, 16'd0);
        chk("div0 q_out", got_q, 16'd1234);
        chk("div0 err_at_out_r", err_at_r, 1);
        chk("div0 err_held", err_end, 1);
        chk("div0 done_cycle", done_cyc, 6);
        check_div(16'd100, 16'd7, 1'b0);
`else
        run_div(16'd1234, 16'd0, 1'b0);
        chk("div0 err_never", n_err, 0);
        chk("div0 shifts", n_c6, 16);
        chk("div0 qwrites", n_c5, 16);
        chk("div0 done_pulses", n_done, 1);
`endif

        // start held for the whole operation gives one division only
        check_div(16'd100, 16'd7, 1'b1);

        // Reset during iteration 8, then a fresh division
        clr_obs();
        dvd_in = 16'd100; dvs_in = 16'd7; hi_word = 16'd0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            sample(cyc);
            if (n_c6 == 8) break;
        end
        chk("midrst reached_iter8", n_c6, 8);
        rst_b = 1'b0;
        #1;
        chk("midrst outs_immediate", outs, 13'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        clr_obs();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            sample(0);
        end
        chk("midrst no_done", n_done, 0);
        chk("midrst no_restart", n_c0, 0);
        check_div(16'd100, 16'd7, 1'b0);

        // Random operands, divisor kept below 0x8000
        for (int i = 0; i < 12; i++) begin
            logic [15:0] dv, ds;
            dv = 16'($urandom_range(0, 16'hFFFF));
            ds = 16'($urandom_range(1, 16'h7FFF));
            if (i == 0) ds = 16'h7FFF;
            check_div(dv, ds, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
